// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte
// (start, 8 data LSB first, odd parity, stop) on device clock falls, checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned INH_W   = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           clk_s, data_s;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 clk_oe_d, data_oe_d, busy_d, done_d, err_d;
  logic                 clk_fall, timed_out;

  // Pin synchronisers; idle bus level is high so they reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s  <= 3'b111;
      data_s <= 3'b111;
    end else begin
      clk_s  <= {clk_s[1:0], ps2_clk};
      data_s <= {data_s[1:0], ps2_data};
    end
  end

  assign clk_fall  = clk_s[2] & ~clk_s[1];
  assign timed_out = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

  // Frame shifts out LSB first; frame bit 9 is the stop bit, so fall #10 releases data.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = err;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          err_d     = 1'b0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      default: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timed_out) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (state_q == S_WAITIDLE) begin
          if (clk_s[2] && data_s[2]) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (clk_fall) begin
          if (state_q == S_ACK) begin
            err_d   = data_s[2];
            state_d = S_WAITIDLE;
          end else begin
            data_oe_d = ~frame_q[0];
            frame_d   = {1'b1, frame_q[FRAME_W-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            state_d   = (bit_cnt_q == BIT_W'(9)) ? S_ACK : S_SHIFT;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames over
// open-drain pins and every observation is compared against hand-computed values.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 30;
  localparam int unsigned TO   = 1500;
  localparam int unsigned HALF = 10;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pin, ps2_data_pin;

  int pass_cnt;
  int total_cnt;

  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk_pin),
    .ps2_data   (ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse tx_start for one edge; returns {busy, ps2_clk_oe} just after acceptance.
  task automatic start_tx(input logic [7:0] b, output logic [1:0] acc);
    @(posedge clk);
    #1 tx_data = b;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    acc = {busy, ps2_clk_oe};
  endtask

  // Wait for the start bit (clock released, data driven); counts inhibit cycles.
  task automatic wait_start(output int hi, output bit ok);
    hi = 0;
    ok = 1'b0;
    for (int i = 0; i < int'(INH) + 50; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) hi++;
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One device clock period: high, fall, sample data mid-low, rise.
  task automatic dev_pulse(output logic lvl);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    lvl = ps2_data_pin;
    dev_clk_low = 1'b0;
  endtask

  // Ten falls observing the driven bits, then fall #11 with optional ACK.
  task automatic dev_frame(input logic ack, output logic [9:0] seen);
    logic dummy;
    for (int k = 0; k < 10; k++) dev_pulse(seen[k]);
    repeat (HALF) @(negedge clk);
    dev_data_low = ack;
    dev_pulse(dummy);
    repeat (2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit got, output logic e,
                           output logic [1:0] oe, output logic [1:0] after);
    n = 0;
    got = 1'b0;
    e = 1'bx;
    oe = 2'bxx;
    after = 2'bxx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
        e = err;
        oe = {ps2_clk_oe, ps2_data_oe};
        @(negedge clk);
        after = {busy, done};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
    else pass_cnt++;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0)
      $display("FAIL idle_after_reset: got %b expected 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [1:0] acc, oe, after;
    logic [9:0] seen;
    logic e;
    int hi, n;
    bit ok, got;
    start_tx(8'hED, acc);
    total_cnt++;
    if (acc !== 2'b11) $display("FAIL basic_accept: got %b expected 11", acc);
    else pass_cnt++;
    wait_start(hi, ok);
    total_cnt++;
    if (!ok || hi != int'(INH)) $display("FAIL basic_inhibit: got ok=%0d cycles=%0d expected 1/%0d", ok, hi, INH);
    else pass_cnt++;
    dev_frame(1'b1, seen);
    total_cnt++;
    if (seen !== 10'h3ED) $display("FAIL basic_frame: got %h expected 3ed", seen);
    else pass_cnt++;
    wait_done(200, n, got, e, oe, after);
    total_cnt++;
    if (!got || e !== 1'b0) $display("FAIL basic_done: got done=%0d err=%b expected 1/0", got, e);
    else pass_cnt++;
    total_cnt++;
    if (oe !== 2'b00) $display("FAIL basic_release: got %b expected 00", oe);
    else pass_cnt++;
    total_cnt++;
    if (after !== 2'b00) $display("FAIL basic_after_done: got busy,done=%b expected 00", after);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3] = '{8'h01, 8'hFF, 8'h00};
    logic [9:0] exp_fr [3] = '{10'h201, 10'h3FF, 10'h300};
    logic       exp_par [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0] acc, oe, after;
    logic [9:0] seen;
    logic e;
    int hi, n;
    bit ok, got;
    for (int t = 0; t < 3; t++) begin
      start_tx(bytes[t], acc);
      wait_start(hi, ok);
      dev_frame(1'b1, seen);
      total_cnt++;
      if (seen[8] !== exp_par[t])
        $display("FAIL parity_%h: got %b expected %b", bytes[t], seen[8], exp_par[t]);
      else pass_cnt++;
      total_cnt++;
      if (seen !== exp_fr[t]) $display("FAIL frame_%h: got %h expected %h", bytes[t], seen, exp_fr[t]);
      else pass_cnt++;
      wait_done(200, n, got, e, oe, after);
      total_cnt++;
      if (!got || e !== 1'b0) $display("FAIL done_%h: got done=%0d err=%b expected 1/0", bytes[t], got, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_no_ack();
    logic [1:0] acc, oe, after;
    logic [9:0] seen;
    logic e;
    int hi, n;
    bit ok, got;
    start_tx(8'hF4, acc);
    wait_start(hi, ok);
    dev_frame(1'b0, seen);
    total_cnt++;
    if (seen !== 10'h2F4) $display("FAIL noack_frame: got %h expected 2f4", seen);
    else pass_cnt++;
    wait_done(200, n, got, e, oe, after);
    total_cnt++;
    if (!got || e !== 1'b1) $display("FAIL noack_err: got done=%0d err=%b expected 1/1", got, e);
    else pass_cnt++;
    total_cnt++;
    if (oe !== 2'b00) $display("FAIL noack_release: got %b expected 00", oe);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [1:0] acc, oe, after;
    logic e;
    int hi, n;
    bit ok, got;
    start_tx(8'hFF, acc);
    wait_start(hi, ok);
    total_cnt++;
    if (!ok) $display("FAIL timeout_start: got ok=%0d expected 1", ok);
    else pass_cnt++;
    wait_done(int'(TO) + 50, n, got, e, oe, after);
    total_cnt++;
    if (!got || n != int'(TO)) $display("FAIL timeout_cycles: got done=%0d cycles=%0d expected 1/%0d", got, n, TO);
    else pass_cnt++;
    total_cnt++;
    if (e !== 1'b1 || oe !== 2'b00) $display("FAIL timeout_state: got err=%b oe=%b expected 1/00", e, oe);
    else pass_cnt++;
    total_cnt++;
    if (after !== 2'b00) $display("FAIL timeout_after: got busy,done=%b expected 00", after);
    else pass_cnt++;
  endtask

  task automatic test_ignore_busy();
    logic [1:0] acc, oe, after;
    logic [9:0] seen;
    logic e;
    int hi, n;
    bit ok, got;
    start_tx(8'hA3, acc);
    @(posedge clk);
    #1 tx_data = 8'h55;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    total_cnt++;
    if ({busy, ps2_clk_oe} !== 2'b11) $display("FAIL ignore_still_inhibit: got %b expected 11", {busy, ps2_clk_oe});
    else pass_cnt++;
    wait_start(hi, ok);
    dev_frame(1'b1, seen);
    total_cnt++;
    if (seen !== 10'h3A3) $display("FAIL ignore_frame: got %h expected 3a3", seen);
    else pass_cnt++;
    wait_done(200, n, got, e, oe, after);
    total_cnt++;
    if (!got || e !== 1'b0 || after !== 2'b00)
      $display("FAIL ignore_done: got done=%0d err=%b after=%b expected 1/0/00", got, e, after);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] acc, oe, after;
    logic [9:0] seen;
    logic lvl, e;
    int hi, n;
    bit ok, got;
    start_tx(8'h0F, acc);
    wait_start(hi, ok);
    for (int k = 0; k < 4; k++) dev_pulse(lvl);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    total_cnt++;
    if ({busy, ps2_data_oe} !== 2'b11) $display("FAIL midrst_pre: got busy,data_oe=%b expected 11", {busy, ps2_data_oe});
    else pass_cnt++;
    #1 rst = 1'b0;
    #1;
    total_cnt++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0)
      $display("FAIL midrst_async: got %b expected 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
    else pass_cnt++;
    dev_clk_low = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    start_tx(8'h3C, acc);
    total_cnt++;
    if (acc !== 2'b11) $display("FAIL midrst_accept: got %b expected 11", acc);
    else pass_cnt++;
    wait_start(hi, ok);
    dev_frame(1'b1, seen);
    total_cnt++;
    if (seen !== 10'h33C) $display("FAIL midrst_frame: got %h expected 33c", seen);
    else pass_cnt++;
    wait_done(200, n, got, e, oe, after);
    total_cnt++;
    if (!got || e !== 1'b0) $display("FAIL midrst_done: got done=%0d err=%b expected 1/0", got, e);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst          = 1'b0;
    tx_data      = 8'h00;
    tx_start     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_no_ack();
    test_timeout();
    test_ignore_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
